pc_seq_ctrl: RTL

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_seq_ctrl_ret_stack.sv | 57 +++++
 rtl/pc_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// The optional return stack is enabled with PC_SEQ_RAS_EN.
package pc_seq_pkg;

  localparam int PC_W_DEF = 6;
  localparam logic [5:0] RESET_PC_DEF = 6'd0;

  // Push-depth counter width; lets pops keep walking the ring after overwrites.
  localparam int RAS_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_seq_ctrl_ret_stack.sv
// Circular return-address stack: a push to a full stack overwrites the oldest slot.
// Only instantiated when PC_SEQ_RAS_EN is defined.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = RAS_CNT_W;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] ptr_prv;
  logic [CW-1:0] cnt;

  // ptr is the next write slot; the top of stack sits one slot behind it.
  assign ptr_nxt = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  assign ptr_prv = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);

  assign top   = mem[ptr_prv];
  assign empty = (cnt == '0);
  assign full  = (cnt >= CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr_nxt;
      if (cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr <= ptr_prv;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: sequential fetch, branch/jump redirect with one-cycle flush, halt.
// Define PC_SEQ_RAS_EN to add call/return through a circular return stack.
//
// state | meaning
// RUN   | fetching; decode inputs evaluated (halt > stall > taken > pc+1)
// FLUSH | redirect just taken; squash decode, advance pc+1 (stall holds)
// HALT  | stopped; pc frozen until rst
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_req,
  input  logic            br_cond,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            mux_sel,
  output logic            flush,
  output logic            halted,
  output logic            ras_err
);

  state_t          state;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic            br_taken;
  logic            taken;
  logic            advance;

  assign pc_inc   = pc + PC_W'(1);
  assign br_taken = br_req & br_cond;
  assign advance  = (state == RUN) & ~halt & ~stall;

`ifdef PC_SEQ_RAS_EN
  logic            is_ret;
  logic            push;
  logic            pop;
  logic            ras_under;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full_unused;

  // A ret decoded together with any other redirect defers to the explicit target.
  assign is_ret    = ret & ~(br_taken | jmp | call);
  assign taken     = br_taken | jmp | call | ret;
  assign target    = is_ret ? (ras_empty ? RESET_PC : ras_top) : br_target;
  assign push      = advance & call;
  assign pop       = advance & is_ret & ~ras_empty;
  assign ras_under = advance & is_ret & ras_empty;

  ret_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_err <= 1'b0;
    end else if (ras_under) begin
      ras_err <= 1'b1;
    end
  end
`else
  localparam int RAS_DEPTH_unused = RAS_DEPTH;
  logic ret_unused;

  assign ret_unused = ret;
  assign taken      = br_taken | jmp | call;
  assign target     = br_target;
  assign ras_err    = 1'b0;
`endif

  assign mux_sel = ~rst & advance & taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      flush  <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!stall) begin
            if (taken) begin
              pc    <= target;
              state <= FLUSH;
              flush <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        FLUSH: begin
          if (!stall) begin
            pc    <= pc_inc;
            state <= RUN;
            flush <= 1'b0;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          flush  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
